// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : EX-stage branch resolver. Evaluates the branch condition,
//               reports the resolved direction to the correlating predictor,
//               and on a misprediction redirects fetch and flushes the front
//               end for FLUSH_CYCLES cycles. Keeps saturating statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      id_target,
    input  logic [1:0]       id_br_type,
    input  logic [31:0]      id_rs1_val,
    input  logic [31:0]      id_rs2_val,
    input  logic             id_pred,
    output logic             actual_outcome,
    output logic             branch_EX_done,
    output logic [31:0]      PC_prev,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             busy,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    // Flush down-counter must hold FLUSH_CYCLES-1; keep at least one bit.
    localparam int               c_FC_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [c_FC_W-1:0] c_FC_LOAD = c_FC_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_FLUSH = 1'b1;

    localparam logic [1:0] c_BR_BEQ = 2'b00;
    localparam logic [1:0] c_BR_BNE = 2'b01;
    localparam logic [1:0] c_BR_BLT = 2'b10;

    logic [0:0]        r_state;
    logic [c_FC_W-1:0] r_flush_cnt;
    logic              r_actual_outcome;
    logic              r_branch_done;
    logic [31:0]       r_pc_prev;
    logic              r_redirect_valid;
    logic [31:0]       r_redirect_pc;
    logic [CNT_W-1:0]  r_br_count;
    logic [CNT_W-1:0]  r_mispred_count;

    logic              w_accept;
    logic              w_cond;
    logic              w_mispred;
    logic [31:0]       w_fallthrough;

    // Branches arriving while the front end is being flushed are dropped.
    assign w_accept      = id_valid && (r_state == c_ST_IDLE);
    assign w_mispred     = w_cond ^ id_pred;
    assign w_fallthrough = id_pc + 32'd4;

    // Branch condition evaluation; BLT/BGE compare as signed values.
    always_comb begin
        w_cond = 1'b0;
        case (id_br_type)
            c_BR_BEQ: w_cond = (id_rs1_val == id_rs2_val);
            c_BR_BNE: w_cond = (id_rs1_val != id_rs2_val);
            c_BR_BLT: w_cond = ($signed(id_rs1_val) <  $signed(id_rs2_val));
            default:  w_cond = ($signed(id_rs1_val) >= $signed(id_rs2_val));
        endcase
    end

    // Flush FSM: a mispredict holds the front end in FLUSH for FLUSH_CYCLES cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_flush_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept && w_mispred) begin
                        r_state     <= c_ST_FLUSH;
                        r_flush_cnt <= c_FC_LOAD;
                    end
                end
                default: begin
                    if (r_flush_cnt == '0) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    // Resolution report and redirect; outcome, PC and redirect target hold between events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_actual_outcome <= 1'b0;
            r_branch_done    <= 1'b0;
            r_pc_prev        <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_branch_done    <= w_accept;
            r_redirect_valid <= w_accept && w_mispred;
            if (w_accept) begin
                r_actual_outcome <= w_cond;
                r_pc_prev        <= id_pc;
                if (w_mispred) begin
                    r_redirect_pc <= w_cond ? id_target : w_fallthrough;
                end
            end
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_count      <= '0;
            r_mispred_count <= '0;
        end else if (w_accept) begin
            if (r_br_count != c_CNT_MAX) begin
                r_br_count <= r_br_count + 1'b1;
            end
            if (w_mispred && (r_mispred_count != c_CNT_MAX)) begin
                r_mispred_count <= r_mispred_count + 1'b1;
            end
        end
    end

    assign actual_outcome = r_actual_outcome;
    assign branch_EX_done = r_branch_done;
    assign PC_prev        = r_pc_prev;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flush          = (r_state == c_ST_FLUSH);
    assign busy           = (r_state == c_ST_FLUSH);
    assign br_count       = r_br_count;
    assign mispred_count  = r_mispred_count;

endmodule
`default_nettype wire
